// File: rtl/pll_supervisor.sv
// PLL supervisor: watches rPLL LOCK, sequences system reset release,
// re-acquires lock through a PLL reset pulse on loss or timeout, and
// derives NUM_CE programmable clock-enable strobes in the PLL clock domain.
module pll_supervisor #(
    parameter int NUM_CE             = 2,
    parameter int DIV_W              = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOSS_FILTER        = 4,
    parameter int PLL_RST_CYCLES     = 32,
    parameter int LOCK_TIMEOUT       = 65536
) (
    input  logic                    clkin,
    input  logic                    rst_n,
    input  logic                    pll_lock,
    input  logic [NUM_CE*DIV_W-1:0] ce_div,
    output logic                    pll_reset,
    output logic                    sys_rst_n,
    output logic                    locked,
    output logic [NUM_CE-1:0]       ce,
    output logic [7:0]              relock_cnt,
    output logic [2:0]              state_o
);

    // The shared counter must hold the largest of the per-state counts.
    localparam int MAX_A   = (LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES;
    localparam int MAX_B   = (RST_HOLD_CYCLES > PLL_RST_CYCLES) ? RST_HOLD_CYCLES : PLL_RST_CYCLES;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_MAX = (MAX_C > LOSS_FILTER) ? MAX_C : LOSS_FILTER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int LOSS_W  = $clog2(LOSS_FILTER + 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_PLL_RST   = 3'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [STB_W-1:0]    stable_cnt_reg, stable_cnt_next;
    logic [LOSS_W-1:0]   loss_cnt_reg, loss_cnt_next;
    logic                lock_meta_reg, lock_s_reg;
    logic                pll_reset_reg, sys_rst_n_reg, locked_reg;
    logic [7:0]          relock_cnt_reg;
    logic                run_enter, run_stay;

    // Two-flop synchroniser for the asynchronous LOCK input.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            lock_meta_reg <= pll_lock;
            lock_s_reg    <= lock_meta_reg;
        end
    end

    // Next-state and counter logic; stable completion outranks the timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_WAIT_LOCK: begin
                if (lock_s_reg && stable_cnt_reg == STB_W'(LOCK_STABLE_CYCLES - 1))
                    state_next = ST_HOLD;
                else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1))
                    state_next = ST_PLL_RST;
            end
            ST_HOLD: begin
                if (!lock_s_reg)
                    state_next = ST_WAIT_LOCK;
                else if (cnt_reg == CNT_W'(RST_HOLD_CYCLES - 1))
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s_reg && loss_cnt_reg == LOSS_W'(LOSS_FILTER - 1))
                    state_next = ST_PLL_RST;
            end
            ST_PLL_RST: begin
                if (cnt_reg == CNT_W'(PLL_RST_CYCLES - 1))
                    state_next = ST_WAIT_LOCK;
            end
            default: state_next = ST_WAIT_LOCK;
        endcase

        cnt_next = cnt_reg;
        if (state_next != state_reg)
            cnt_next = '0;
        else if (cnt_reg != CNT_W'(CNT_MAX))
            cnt_next = cnt_reg + CNT_W'(1);

        stable_cnt_next = '0;
        if (state_reg == ST_WAIT_LOCK && state_next == ST_WAIT_LOCK && lock_s_reg)
            stable_cnt_next = stable_cnt_reg + STB_W'(1);

        loss_cnt_next = '0;
        if (state_reg == ST_RUN && state_next == ST_RUN && !lock_s_reg)
            loss_cnt_next = loss_cnt_reg + LOSS_W'(1);
    end

    // State, counters and registered outputs, all derived from the next state.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_WAIT_LOCK;
            cnt_reg        <= '0;
            stable_cnt_reg <= '0;
            loss_cnt_reg   <= '0;
            pll_reset_reg  <= 1'b0;
            sys_rst_n_reg  <= 1'b0;
            locked_reg     <= 1'b0;
            relock_cnt_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            stable_cnt_reg <= stable_cnt_next;
            loss_cnt_reg   <= loss_cnt_next;
            pll_reset_reg  <= (state_next == ST_PLL_RST);
            sys_rst_n_reg  <= (state_next == ST_RUN);
            locked_reg     <= (state_next == ST_RUN);
            if (state_next == ST_PLL_RST && state_reg != ST_PLL_RST && relock_cnt_reg != 8'hFF)
                relock_cnt_reg <= relock_cnt_reg + 8'd1;
        end
    end

    assign run_enter = (state_next == ST_RUN) && (state_reg != ST_RUN);
    // Strobes are suppressed in the last RUN cycle so nothing fires as reset drops.
    assign run_stay  = (state_next == ST_RUN) && (state_reg == ST_RUN);

    generate
        for (genvar gi = 0; gi < NUM_CE; gi++) begin : g_ce
            logic [DIV_W-1:0] div_reg;
            logic [DIV_W-1:0] ce_cnt_reg;
            logic             wrap;

            // Divisors 0 and 1 both mean "every cycle".
            assign wrap   = (div_reg <= DIV_W'(1)) || (ce_cnt_reg == div_reg - DIV_W'(1));
            assign ce[gi] = run_stay && wrap;

            // Divisor is captured only at period boundaries so changes never shorten a period.
            always_ff @(posedge clkin or negedge rst_n) begin
                if (!rst_n) begin
                    div_reg    <= '0;
                    ce_cnt_reg <= '0;
                end else if (run_enter) begin
                    div_reg    <= ce_div[gi*DIV_W +: DIV_W];
                    ce_cnt_reg <= '0;
                end else if (run_stay) begin
                    if (wrap) begin
                        div_reg    <= ce_div[gi*DIV_W +: DIV_W];
                        ce_cnt_reg <= '0;
                    end else begin
                        ce_cnt_reg <= ce_cnt_reg + DIV_W'(1);
                    end
                end else begin
                    ce_cnt_reg <= '0;
                end
            end
        end
    endgenerate

    assign pll_reset  = pll_reset_reg;
    assign sys_rst_n  = sys_rst_n_reg;
    assign locked     = locked_reg;
    assign relock_cnt = relock_cnt_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench for pll_supervisor: stimulus pushes hand-computed
// expected output snapshots tagged with a cycle, a monitor pops and compares.
module tb_pll_supervisor;

    localparam int NUM_CE = 2;
    localparam int DIV_W  = 16;

    localparam logic [2:0] S_WAIT = 3'd0;
    localparam logic [2:0] S_HOLD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_PRST = 3'd3;

    logic                    clkin = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    pll_lock = 1'b0;
    logic [NUM_CE*DIV_W-1:0] ce_div;
    logic                    pll_reset, sys_rst_n, locked;
    logic [NUM_CE-1:0]       ce;
    logic [7:0]              relock_cnt;
    logic [2:0]              state_o;

    pll_supervisor #(
        .NUM_CE(NUM_CE), .DIV_W(DIV_W), .LOCK_STABLE_CYCLES(8), .RST_HOLD_CYCLES(4),
        .LOSS_FILTER(3), .PLL_RST_CYCLES(5), .LOCK_TIMEOUT(64)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .ce_div(ce_div),
        .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .locked(locked), .ce(ce),
        .relock_cnt(relock_cnt), .state_o(state_o)
    );

    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        int         nid;
        bit         now;
        logic [2:0] st;
        logic       prst;
        logic       srstn;
        logic       lck;
        logic [1:0] cev;
        logic [7:0] rc;
    } exp_t;

    exp_t  sb[$];
    string names[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    edge0 = 0;
    event  sample_now;

    task automatic push_exp(input int c, input bit now, input logic [2:0] st, input logic prst,
                            input logic srstn, input logic lck, input logic [1:0] cev,
                            input logic [7:0] rc, input string name);
        exp_t e;
        e.cyc = c; e.nid = names.size(); e.now = now; e.st = st; e.prst = prst;
        e.srstn = srstn; e.lck = lck; e.cev = cev; e.rc = rc;
        names.push_back(name);
        sb.push_back(e);
    endtask

    // Expected snapshot after edge k of the current run (edge 0 = first edge after release).
    task automatic exp_after(input int k, input logic [2:0] st, input logic prst, input logic srstn,
                             input logic lck, input logic [1:0] cev, input logic [7:0] rc,
                             input string name);
        push_exp(edge0 + k, 1'b0, st, prst, srstn, lck, cev, rc, name);
    endtask

    task automatic exp_now_reset(input string name);
        push_exp(cyc, 1'b1, S_WAIT, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, name);
        -> sample_now;
    endtask

    task automatic go_to(input int k);
        while (cyc < edge0 + k) @(negedge clkin);
    endtask

    task automatic release_rst();
        @(negedge clkin);
        edge0 = cyc + 1;
        rst_n = 1'b1;
    endtask

    task automatic clean_checks(input string tag);
        exp_after(8,  S_WAIT, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, {tag, "_wait_e8"});
        exp_after(9,  S_HOLD, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, {tag, "_hold_e9"});
        exp_after(12, S_HOLD, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, {tag, "_hold_e12"});
        exp_after(13, S_RUN,  1'b0, 1'b1, 1'b1, 2'b10, 8'd0, {tag, "_run_e13"});
        exp_after(15, S_RUN,  1'b0, 1'b1, 1'b1, 2'b11, 8'd0, {tag, "_ce_e15"});
    endtask

    // Monitor: compares every queued snapshot due at this negedge or flagged immediate.
    initial begin : monitor
        exp_t        e;
        logic [15:0] got, want;
        forever begin
            @(negedge clkin or sample_now);
            while (sb.size() > 0 && (sb[0].now || sb[0].cyc <= cyc)) begin
                e = sb.pop_front();
                n_checks++;
                got  = {state_o, pll_reset, sys_rst_n, locked, ce, relock_cnt};
                want = {e.st, e.prst, e.srstn, e.lck, e.cev, e.rc};
                if (!e.now && e.cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s sample missed: due cyc %0d, now cyc %0d", names[e.nid], e.cyc, cyc);
                end else if (got !== want) begin
                    n_fail++;
                    $display("FAIL %s got st=%0d prst=%b srst_n=%b locked=%b ce=%b rc=%0d, want st=%0d prst=%b srst_n=%b locked=%b ce=%b rc=%0d",
                             names[e.nid], state_o, pll_reset, sys_rst_n, locked, ce, relock_cnt,
                             e.st, e.prst, e.srstn, e.lck, e.cev, e.rc);
                end else begin
                    $display("ok   %s st=%0d prst=%b srst_n=%b locked=%b ce=%b rc=%0d",
                             names[e.nid], state_o, pll_reset, sys_rst_n, locked, ce, relock_cnt);
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        ce_div   = {16'd0, 16'd3};
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        repeat (3) @(negedge clkin);
        #1 exp_now_reset("reset_values");

        // Clean lock, CE divisors with a mid-period change, then loss handling.
        pll_lock = 1'b1;
        release_rst();
        clean_checks("s1");
        exp_after(16, S_RUN, 1'b0, 1'b1, 1'b1, 2'b10, 8'd0, "s5_ce_e16");
        exp_after(18, S_RUN, 1'b0, 1'b1, 1'b1, 2'b11, 8'd0, "s5_ce_e18");
        exp_after(21, S_RUN, 1'b0, 1'b1, 1'b1, 2'b11, 8'd0, "s5_last3_e21");
        exp_after(22, S_RUN, 1'b0, 1'b1, 1'b1, 2'b10, 8'd0, "s5_e22");
        exp_after(25, S_RUN, 1'b0, 1'b1, 1'b1, 2'b10, 8'd0, "s5_e25");
        exp_after(26, S_RUN, 1'b0, 1'b1, 1'b1, 2'b11, 8'd0, "s5_first5_e26");
        exp_after(27, S_RUN, 1'b0, 1'b1, 1'b1, 2'b10, 8'd0, "s5_e27");
        exp_after(31, S_RUN, 1'b0, 1'b1, 1'b1, 2'b11, 8'd0, "s5_second5_e31");
        go_to(20);
        ce_div[15:0] = 16'd5;

        exp_after(36, S_RUN,  1'b0, 1'b1, 1'b1, 2'b11, 8'd0, "s3_short_loss_e36");
        exp_after(38, S_RUN,  1'b0, 1'b1, 1'b1, 2'b10, 8'd0, "s3_short_loss_e38");
        exp_after(43, S_RUN,  1'b0, 1'b1, 1'b1, 2'b10, 8'd0, "s3_loss_e43");
        exp_after(44, S_RUN,  1'b0, 1'b1, 1'b1, 2'b00, 8'd0, "s3_ce_forced_e44");
        exp_after(45, S_PRST, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1, "s3_pllrst_e45");
        exp_after(49, S_PRST, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1, "s3_pllrst_e49");
        exp_after(50, S_WAIT, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1, "s3_wait_e50");
        exp_after(57, S_WAIT, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1, "s3_wait_e57");
        exp_after(58, S_HOLD, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1, "s3_hold_e58");
        exp_after(62, S_RUN,  1'b0, 1'b1, 1'b1, 2'b10, 8'd1, "s3_run_e62");
        go_to(32); pll_lock = 1'b0;
        go_to(34); pll_lock = 1'b1;
        go_to(40); pll_lock = 1'b0;
        go_to(43); pll_lock = 1'b1;

        // Asynchronous reset while in RUN, then clean lock again.
        go_to(63);
        #2 rst_n = 1'b0;
        ce_div = {16'd0, 16'd3};
        #1 exp_now_reset("s6_async_in_run");
        repeat (2) @(negedge clkin);
        release_rst();
        clean_checks("s6a");
        go_to(16);

        // Glitchy lock: one low sample after five good ones.
        @(negedge clkin); rst_n = 1'b0;
        repeat (2) @(negedge clkin);
        release_rst();
        exp_after(14, S_WAIT, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, "s2_wait_e14");
        exp_after(15, S_HOLD, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, "s2_hold_e15");
        exp_after(19, S_RUN,  1'b0, 1'b1, 1'b1, 2'b10, 8'd0, "s2_run_e19");
        go_to(4); pll_lock = 1'b0;
        go_to(5); pll_lock = 1'b1;
        go_to(20);

        // Lock timeout, repeated until relock_cnt saturates.
        @(negedge clkin); rst_n = 1'b0; pll_lock = 1'b0;
        repeat (2) @(negedge clkin);
        release_rst();
        exp_after(62,  S_WAIT, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, "s4_wait_e62");
        exp_after(63,  S_PRST, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1, "s4_timeout1");
        exp_after(67,  S_PRST, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1, "s4_pllrst_e67");
        exp_after(68,  S_WAIT, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1, "s4_wait_e68");
        exp_after(131, S_WAIT, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1, "s4_wait_e131");
        exp_after(132, S_PRST, 1'b1, 1'b0, 1'b0, 2'b00, 8'd2, "s4_timeout2");
        exp_after(63 + 69*254, S_PRST, 1'b1, 1'b0, 1'b0, 2'b00, 8'd255, "s4_timeout255");
        exp_after(63 + 69*255, S_PRST, 1'b1, 1'b0, 1'b0, 2'b00, 8'd255, "s4_timeout256_sat");
        n = 63 + 69*299;
        exp_after(n,     S_PRST, 1'b1, 1'b0, 1'b0, 2'b00, 8'd255, "s4_timeout300_sat");
        exp_after(n + 1, S_PRST, 1'b1, 1'b0, 1'b0, 2'b00, 8'd255, "s4_pllrst_before_async");

        // Asynchronous reset while in PLL_RST, then clean lock again.
        go_to(n + 1);
        #2 rst_n = 1'b0;
        pll_lock = 1'b1;
        #1 exp_now_reset("s6_async_in_pllrst");
        repeat (2) @(negedge clkin);
        release_rst();
        clean_checks("s6b");
        go_to(16);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clkin);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected samples never compared, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Supervises the on-chip rPLL and derives the system reset and clock-enable strobes from its output clock.
- Takes over what the bare PLL wrapper leaves undone: it watches LOCK, holds system reset until lock is stable, and detects loss of lock.
- On loss of lock it pulses the PLL reset and re-acquires lock automatically.
- Provides NUM_CE programmable clock-enable strobes so slower logic (UART, timers) runs on the single PLL clock domain.

Parameters:
- NUM_CE, 2, number of clock-enable channels (1..8).
- DIV_W, 16, width of each channel divisor.
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before leaving WAIT_LOCK.
- RST_HOLD_CYCLES, 16, cycles sys_rst_n stays low after lock is declared stable.
- LOSS_FILTER, 4, consecutive unlocked cycles in RUN that count as loss of lock.
- PLL_RST_CYCLES, 32, length of the pll_reset pulse.
- LOCK_TIMEOUT, 65536, maximum cycles in WAIT_LOCK before forcing a PLL reset.

Ports:
- clkin  in  1  PLL output clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  rPLL LOCK; asynchronous, 2-FF synchronised internally to lock_s.
- ce_div  in  NUM_CE*DIV_W  per-channel divisor; channel k uses bits [k*DIV_W +: DIV_W].
- pll_reset  out  1  drives rPLL RESET, active high.
- sys_rst_n  out  1  registered system reset, active low.
- locked  out  1  high exactly when state is RUN.
- ce  out  NUM_CE  single-cycle clock-enable strobes.
- relock_cnt  out  8  number of PLL resets issued, saturating.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=WAIT_LOCK, all counters 0, sync flops 0.
  - Outputs: pll_reset=0, sys_rst_n=0, locked=0, ce=0, relock_cnt=0.
- States and encodings: WAIT_LOCK=0, HOLD=1, RUN=2, PLL_RST=3.
- One shared cycle counter cnt, sized to the largest count parameter; it clears on every state transition.
- WAIT_LOCK:
  - lock_s=1 increments the stable counter; lock_s=0 clears it.
  - Goes to HOLD on the edge that samples the LOCK_STABLE_CYCLES-th consecutive lock_s=1.
  - cnt counts total cycles in WAIT_LOCK; reaching LOCK_TIMEOUT-1 goes to PLL_RST.
  - If stable completion and timeout occur on the same edge, stable completion wins.
- HOLD:
  - Lasts exactly RST_HOLD_CYCLES cycles, then goes to RUN.
  - lock_s=0 at any cycle in HOLD returns to WAIT_LOCK, with no PLL reset.
- RUN:
  - sys_rst_n=1 and locked=1, both registered and set on the edge entering RUN.
  - A loss counter counts consecutive lock_s=0 cycles; lock_s=1 clears it.
  - Reaching LOSS_FILTER goes to PLL_RST.
  - sys_rst_n and locked drop on that same edge.
- PLL_RST:
  - pll_reset=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK with pll_reset=0.
  - relock_cnt increments on entry and saturates at 255.
- sys_rst_n is 0 in every state other than RUN.
- CE channel k:
  - Counter runs only in RUN and is held at 0 otherwise.
  - Effective divisor d is sampled from ce_div when the counter wraps, and on RUN entry.
  - ce[k] pulses on the cycle the counter equals d-1, then the counter wraps to 0.
  - d=0 or d=1: ce[k]=1 every cycle in RUN.
  - First pulse is d cycles after RUN entry.
  - A ce_div change mid-period takes effect after the current period completes.
- ce is forced to 0 in the cycle RUN is exited, including loss detection.

Test Plan:
Bench parameters: LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, LOSS_FILTER=3, PLL_RST_CYCLES=5, LOCK_TIMEOUT=64, NUM_CE=2.
1. Clean lock: release rst_n, raise pll_lock before edge 0 -> state HOLD after edge 9, sys_rst_n=1 and locked=1 after edge 13, pll_reset never asserted, relock_cnt=0.
2. Glitchy lock: pll_lock low for 1 cycle after 5 stable samples -> stable count restarts; HOLD entry is delayed by exactly 6 cycles versus scenario 1.
3. Loss in RUN:
   - pll_lock low for 2 cycles -> stays RUN.
   - pll_lock low for 3 cycles -> PLL_RST, sys_rst_n=0 the same edge, pll_reset high exactly 5 cycles, relock_cnt=1.
   - pll_lock restored -> re-acquires via WAIT_LOCK.
4. Lock timeout: pll_lock held 0 -> PLL_RST after 64 cycles in WAIT_LOCK; repeat 300 times -> relock_cnt saturates at 255.
5. CE divisors and glitch-free divisor change:
   - ce_div = {16'd0, 16'd3} -> ce[0] pulses every 3rd cycle starting 3 cycles after RUN entry; ce[1] constantly 1 in RUN.
   - Change ce_div[0] to 5 mid-period -> the current 3-cycle period completes, then 5-cycle spacing.
6. Async reset mid-operation: assert rst_n in RUN and in PLL_RST -> all outputs return to reset values immediately without waiting for a clock; full scenario 1 timing reproduced after release.
